freq_step_ctrl: RTL

//  Sequencer for the resonant-frequency tracking loop. Consumes the decision strobes of the peak-current

---
 rtl/freq_step_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/freq_step_ctrl.sv
// Drive-frequency sequencer for the resonant tracking loop.
// Optional FREQ_STEP_HALVE_EN: halve step on direction reversal.
module freq_step_ctrl #(
   parameter int unsigned FW         = 16,
   parameter int unsigned F_INIT     = 40000,
   parameter int unsigned F_MIN      = 30000,
   parameter int unsigned F_MAX      = 50000,
   parameter int unsigned STEP_INIT  = 500,
   parameter int unsigned STEP_MIN   = 10,
   parameter int unsigned SETTLE_CYC = 2500
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          enable,
   input  logic          restart,
   input  logic          freq_ready,
   input  logic          freq_set_up_down,
   input  logic          freq_opt,
   output logic [FW-1:0] freq_word,
   output logic          freq_update,
   output logic          meas_nrst,
   output logic          locked,
   output logic          at_limit,
   output logic [FW-1:0] step_size
);

   localparam int unsigned CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [FW-1:0] FINIT  = FW'(F_INIT);
   localparam logic [FW-1:0] FMIN   = FW'(F_MIN);
   localparam logic [FW-1:0] FMAX   = FW'(F_MAX);
   localparam logic [FW-1:0] SINIT  = FW'(STEP_INIT);
   localparam logic [CW-1:0] CNT_LD = CW'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, LOCKED} state_t;

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [FW-1:0] word_d, step_d, step_use;
   logic          upd_d, lim_d;
   logic [FW:0]   sum, diff;

`ifdef FREQ_STEP_HALVE_EN
   localparam logic [FW-1:0] SMIN = FW'(STEP_MIN);
   logic          last_dir, last_dir_d;
   logic [FW-1:0] step_half;

   assign step_half = step_size >> 1;
   assign step_use  = (freq_set_up_down == last_dir) ? step_size :
                      (step_half < SMIN) ? SMIN : step_half;
`else
   assign step_use = step_size;
`endif

   assign sum  = {1'b0, freq_word} + {1'b0, step_use};
   assign diff = {1'b0, freq_word} - {1'b0, step_use};

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      word_d  = freq_word;
      step_d  = step_size;
      upd_d   = 1'b0;
      lim_d   = at_limit;
`ifdef FREQ_STEP_HALVE_EN
      last_dir_d = last_dir;
`endif
      if (!enable) begin
         state_d = IDLE;
      end else if (restart) begin
         state_d = SETTLE;
         cnt_d   = CNT_LD;
`ifdef FREQ_STEP_HALVE_EN
         step_d  = SINIT;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               state_d = SETTLE;
               cnt_d   = CNT_LD;
            end
            SETTLE: begin
               if (cnt == '0) state_d = MEASURE;
               else           cnt_d   = cnt - CW'(1);
            end
            MEASURE: begin
               if (freq_opt) begin
                  state_d = LOCKED;
               end else if (freq_ready) begin
                  state_d = SETTLE;
                  cnt_d   = CNT_LD;
                  upd_d   = 1'b1;
`ifdef FREQ_STEP_HALVE_EN
                  step_d     = step_use;
                  last_dir_d = freq_set_up_down;
`endif
                  // Clamped steps still pulse update and re-blank.
                  if (freq_set_up_down) begin
                     lim_d  = sum > {1'b0, FMAX};
                     word_d = lim_d ? FMAX : sum[FW-1:0];
                  end else begin
                     lim_d  = diff[FW] || (diff[FW-1:0] < FMIN);
                     word_d = lim_d ? FMIN : diff[FW-1:0];
                  end
               end
            end
            LOCKED: begin
               state_d = LOCKED;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= IDLE;
         cnt         <= '0;
         freq_word   <= FINIT;
         step_size   <= SINIT;
         freq_update <= 1'b0;
         meas_nrst   <= 1'b0;
         locked      <= 1'b0;
         at_limit    <= 1'b0;
`ifdef FREQ_STEP_HALVE_EN
         last_dir    <= 1'b1;
`endif
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         freq_word   <= word_d;
         step_size   <= step_d;
         freq_update <= upd_d;
         meas_nrst   <= (state_d == MEASURE) || (state_d == LOCKED);
         locked      <= (state_d == LOCKED);
         at_limit    <= lim_d;
`ifdef FREQ_STEP_HALVE_EN
         last_dir    <= last_dir_d;
`endif
      end
   end

endmodule
